// File: rtl/huffman_decoder_if.sv
// Table-load, code-word input and symbol output signals of the Huffman decoder.
// The master side drives the table and the code words; the slave side is the decoder.
interface huffman_decoder_if #(
  parameter int unsigned SYM_W  = 6,
  parameter int unsigned CODE_W = 8,
  parameter int unsigned LEN_W  = 4
);
  logic              tbl_write;
  logic [SYM_W-1:0]  tbl_symbol;
  logic [CODE_W-1:0] tbl_code;
  logic [LEN_W-1:0]  tbl_length;
  logic [31:0]       in_data;
  logic [5:0]        in_length;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [SYM_W-1:0]  out_symbol;
  logic              out_valid;
  logic              out_ready;
  logic              code_error;
  logic [LEN_W-1:0]  pending_bits;

  modport master (
    output tbl_write, tbl_symbol, tbl_code, tbl_length,
    output in_data, in_length, in_valid, flush, out_ready,
    input  in_ready, out_symbol, out_valid, code_error, pending_bits
  );

  modport slave (
    input  tbl_write, tbl_symbol, tbl_code, tbl_length,
    input  in_data, in_length, in_valid, flush, out_ready,
    output in_ready, out_symbol, out_valid, code_error, pending_bits
  );
endinterface

// File: rtl/huffman_decoder.sv
// Bit-serial Huffman decoder: shifts packed MSB-first code bits into a prefix and
// matches it against a writable code table every cycle.
module huffman_decoder #(
  parameter int unsigned SYM_W  = 6,
  parameter int unsigned CODE_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input logic              clock,
  input logic              reset,
  huffman_decoder_if.slave bus
);
  localparam int unsigned Depth = 2 ** SYM_W;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] tbl_code_q [Depth];
  logic [LEN_W-1:0]  tbl_len_q  [Depth];
  logic [31:0]       word_q, word_d;
  logic [5:0]        bits_left_q, bits_left_d;
  // A full CODE_W-bit prefix never survives a step, so one bit less is stored.
  logic [CODE_W-2:0] acc_q, acc_d;
  logic [LEN_W-1:0]  acc_len_q, acc_len_d;
  logic [SYM_W-1:0]  out_symbol_q, out_symbol_d;
  logic              out_valid_q, out_valid_d;
  logic              code_error_q, code_error_d;

  logic              advance, bit_in, hit;
  logic [4:0]        bit_idx;
  logic [CODE_W-1:0] cand, mask;
  logic [LEN_W-1:0]  cand_len;
  logic [SYM_W-1:0]  hit_idx;

  always_comb begin
    bit_idx  = 5'(bits_left_q - 6'd1);
    bit_in   = word_q[bit_idx];
    cand     = {acc_q, bit_in};
    cand_len = acc_len_q + LEN_W'(1);
    mask     = '0;
    for (int i = 0; i < int'(CODE_W); i++) begin
      mask[i] = (i < int'(cand_len));
    end
    hit     = 1'b0;
    hit_idx = '0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int k = int'(Depth) - 1; k >= 0; k--) begin
      if (tbl_len_q[k] == cand_len && ((tbl_code_q[k] ^ cand) & mask) == '0) begin
        hit     = 1'b1;
        hit_idx = SYM_W'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    bits_left_d  = bits_left_q;
    acc_d        = acc_q;
    acc_len_d    = acc_len_q;
    out_symbol_d = out_symbol_q;
    out_valid_d  = out_valid_q & ~bus.out_ready;
    code_error_d = 1'b0;
    advance      = (state_q == StShift) && (!out_valid_q || bus.out_ready);
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          word_d      = bus.in_data;
          bits_left_d = bus.in_length;
          if (bus.in_length != 6'd0) state_d = StShift;
        end else if (bus.flush) begin
          acc_d     = '0;
          acc_len_d = '0;
        end
      end
      StShift: begin
        if (advance) begin
          if (hit) begin
            out_symbol_d = hit_idx;
            out_valid_d  = 1'b1;
            acc_len_d    = '0;
          end else if (cand_len == LEN_W'(CODE_W)) begin
            code_error_d = 1'b1;
            acc_len_d    = '0;
          end else begin
            acc_d     = cand[CODE_W-2:0];
            acc_len_d = cand_len;
          end
          bits_left_d = bits_left_q - 6'd1;
          if (bits_left_q == 6'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      word_q       <= '0;
      bits_left_q  <= '0;
      acc_q        <= '0;
      acc_len_q    <= '0;
      out_symbol_q <= '0;
      out_valid_q  <= 1'b0;
      code_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      bits_left_q  <= bits_left_d;
      acc_q        <= acc_d;
      acc_len_q    <= acc_len_d;
      out_symbol_q <= out_symbol_d;
      out_valid_q  <= out_valid_d;
      code_error_q <= code_error_d;
    end
  end

  // Only the lengths need clearing: a zero length marks the entry invalid.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < int'(Depth); k++) tbl_len_q[k] <= '0;
    end else if (bus.tbl_write) begin
      tbl_len_q[bus.tbl_symbol] <= bus.tbl_length;
    end
  end

  always_ff @(posedge clock) begin
    if (bus.tbl_write) tbl_code_q[bus.tbl_symbol] <= bus.tbl_code;
  end

  assign bus.in_ready     = (state_q == StIdle);
  assign bus.out_symbol   = out_symbol_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.code_error   = code_error_q;
  assign bus.pending_bits = acc_len_q;
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: decode, word spanning, errors, backpressure,
// flush, zero-length words, reset and match priority.
module tb_huffman_decoder;
  logic clock = 1'b0;
  logic reset;

  huffman_decoder_if bus ();

  huffman_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int c      = 0;
  int rdy_cyc;
  int got_sym [$];
  int got_cyc [$];
  int err_cyc [$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge and log handshakes.
  task automatic tick();
    @(posedge clock);
    #1;
    c++;
    if (bus.out_valid && bus.out_ready) begin
      got_sym.push_back(int'(bus.out_symbol));
      got_cyc.push_back(c);
    end
    if (bus.code_error) err_cyc.push_back(c);
    if (bus.in_ready && rdy_cyc < 0) rdy_cyc = c;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    c = 0;
    rdy_cyc = -1;
    got_sym.delete();
    got_cyc.delete();
    err_cyc.delete();
  endtask

  task automatic write_entry(input int sym, input int code, input int len);
    bus.tbl_write  = 1'b1;
    bus.tbl_symbol = 6'(sym);
    bus.tbl_code   = 8'(code);
    bus.tbl_length = 4'(len);
    tick();
    bus.tbl_write  = 1'b0;
  endtask

  // Presents a word while the decoder is idle; after return c=1 is the cycle after acceptance.
  task automatic send(input logic [31:0] data, input int len);
    bus.in_data   = data;
    bus.in_length = 6'(len);
    bus.in_valid  = 1'b1;
    clear_log();
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic expect_syms(input string name, input int n, input int es[4], input int ec[4]);
    check({name, "_count"}, 32'(got_sym.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_sym.size()) begin
        check($sformatf("%s_sym%0d", name, i), 32'(got_sym[i]), 32'(es[i]));
        check($sformatf("%s_cyc%0d", name, i), 32'(got_cyc[i]), 32'(ec[i]));
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.tbl_write  = 1'b0;
    bus.tbl_symbol = '0;
    bus.tbl_code   = '0;
    bus.tbl_length = '0;
    bus.in_data    = '0;
    bus.in_length  = '0;
    bus.in_valid   = 1'b0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
    rdy_cyc        = -1;
    run(2);
    reset = 1'b0;
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_symbol", 32'(bus.out_symbol), 32'd0);
    check("rst_code_error", 32'(bus.code_error), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_pending", 32'(bus.pending_bits), 32'd0);

    // Basic decode: 0 | 10 | 11 | 0
    write_entry(0, 'b0, 1);
    write_entry(1, 'b10, 2);
    write_entry(2, 'b11, 2);
    send(32'b010110, 6);
    check("basic_busy", 32'(bus.in_ready), 32'd0);
    run(8);
    expect_syms("basic", 4, '{0, 1, 2, 0}, '{2, 4, 6, 7});
    check("basic_ready_cyc", 32'(rdy_cyc), 32'd7);

    // A code straddling two one-bit words
    send(32'b1, 1);
    run(3);
    check("span_pending", 32'(bus.pending_bits), 32'd1);
    check("span_first_none", 32'(got_sym.size()), 32'd0);
    send(32'b1, 1);
    run(3);
    expect_syms("span", 1, '{2, 0, 0, 0}, '{2, 0, 0, 0});
    check("span_pending_after", 32'(bus.pending_bits), 32'd0);

    // Eight unmatched bits raise a single error pulse
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_entry(0, 'b0, 1);
    send(32'hFF, 8);
    run(10);
    check("err_pulses", 32'(err_cyc.size()), 32'd1);
    if (err_cyc.size() > 0) check("err_cyc", 32'(err_cyc[0]), 32'd9);
    check("err_no_sym", 32'(got_sym.size()), 32'd0);
    check("err_pending", 32'(bus.pending_bits), 32'd0);
    send(32'b0, 1);
    run(3);
    expect_syms("post_err", 1, '{0, 0, 0, 0}, '{2, 0, 0, 0});

    // Backpressure: hold the first symbol for five cycles
    write_entry(1, 'b10, 2);
    write_entry(2, 'b11, 2);
    send(32'b010110, 6);
    tick();
    check("bp_first_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold_sym%0d", i), 32'(bus.out_symbol), 32'd0);
      check($sformatf("bp_hold_pend%0d", i), 32'(bus.pending_bits), 32'd0);
      check($sformatf("bp_hold_rdy%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    run(7);
    expect_syms("bp", 4, '{0, 1, 2, 0}, '{2, 9, 11, 12});

    // Flush in idle clears the prefix; zero-length word is a no-op
    send(32'b1, 1);
    run(2);
    check("fl_pending", 32'(bus.pending_bits), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_cleared", 32'(bus.pending_bits), 32'd0);
    send(32'hFFFF_FFFF, 0);
    check("zl_ready", 32'(bus.in_ready), 32'd1);
    check("zl_pending", 32'(bus.pending_bits), 32'd0);
    check("zl_valid", 32'(bus.out_valid), 32'd0);
    send(32'b11, 2);
    run(4);
    expect_syms("zl_next", 1, '{2, 0, 0, 0}, '{3, 0, 0, 0});
    // Flush together with an accepted word is ignored
    send(32'b1, 1);
    run(2);
    bus.flush = 1'b1;
    send(32'b1, 1);
    bus.flush = 1'b0;
    run(3);
    expect_syms("fl_with_word", 1, '{2, 0, 0, 0}, '{2, 0, 0, 0});

    // Reset in the middle of a word clears state and table
    send(32'b010110, 6);
    run(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_pending", 32'(bus.pending_bits), 32'd0);
    send(32'h00, 8);
    run(10);
    check("mrst_err_pulses", 32'(err_cyc.size()), 32'd1);
    if (err_cyc.size() > 0) check("mrst_err_cyc", 32'(err_cyc[0]), 32'd9);
    check("mrst_no_sym", 32'(got_sym.size()), 32'd0);

    // Duplicate codes: lowest index wins
    write_entry(9, 'b101, 3);
    write_entry(5, 'b101, 3);
    send(32'b101, 3);
    run(5);
    expect_syms("prio", 1, '{5, 0, 0, 0}, '{4, 0, 0, 0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
